// File: rtl/tff_seq_pkg.sv
// ============================================================================
// Module  : tff_seq_pkg
// Brief   : Mode encodings and FSM state type for tff_count_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tff_seq_pkg;

    localparam logic [1:0] MODE_UP  = 2'b00;
    localparam logic [1:0] MODE_DN  = 2'b01;
    localparam logic [1:0] MODE_LD  = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_RUN   = 2'd2,
        S_FIN   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tff_bank.sv
// ============================================================================
// Module  : tff_bank
// Brief   : WIDTH T flip-flops; each bit toggles when its t_vec bit is set.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        always_ff @(posedge clk) begin
            if (reset) q[i] <= 1'b0;
            else       q[i] <= q[i] ^ t_vec[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/tff_count_sequencer.sv
// ============================================================================
// Module  : tff_count_sequencer
// Brief   : Start/busy/done sequencer driving a T-flip-flop bank as an
//           up/down counter, parallel loader and clear engine.
//           Optional macro TFF_SEQ_HOLD_EN adds a 'hold' input that stalls RUN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_count_sequencer
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [LEN_W-1:0] run_len,
`ifdef TFF_SEQ_HOLD_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q
);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             w_hold;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;

`ifdef TFF_SEQ_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    // Ripple-style toggle terms: bit i flips once all lower bits are 1 (up) or 0 (down)
    assign w_up[0] = 1'b1;
    assign w_dn[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tog
        assign w_up[i] = w_up[i-1] &  q[i-1];
        assign w_dn[i] = w_dn[i-1] & ~q[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_UP;
            target_q <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        t_vec    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    target_d = load_val;
                    cnt_d    = run_len;
                    if (mode[1])                state_d = S_APPLY;
                    else if (run_len == '0)     state_d = S_FIN;
                    else                        state_d = S_RUN;
                end
            end
            S_APPLY: begin
                t_vec   = q ^ ((mode_q == MODE_LD) ? target_q : '0);
                state_d = S_FIN;
            end
            S_RUN: begin
                if (!w_hold) begin
                    if (mode_q == MODE_DN) begin
                        t_vec  = w_dn;
                        wrap_d = (q == '0);
                    end else begin
                        t_vec  = w_up;
                        wrap_d = (q == '1);
                    end
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FIN);
    assign wrap = wrap_q;

    tff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .t_vec (t_vec),
        .q     (q)
    );

endmodule

`default_nettype wire
